// File: rtl/modmul_pkg.sv
// Shared types and defaults for the interleaved modular multiplier.
// Used by modmul_step and modmul_interleaved.
package modmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 256;
    localparam int DEFAULT_TAG_W = 4;

endpackage

// File: rtl/modmul_step.sv
// One MSB-first iteration of interleaved modular multiplication:
// P_next = ((2P mod M) + ybit*X) mod M, computed with one guard bit.
module modmul_step
    import modmul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] M,
    input  logic             ybit,
    output logic [WIDTH-1:0] P_next
);

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] dbl;
    logic [WIDTH:0] red1;
    logic [WIDTH:0] acc;

    // With P < M and X < M, each partial stays below 2M, so one conditional
    // subtraction per step keeps the value reduced and the guard bit suffices.
    always_comb begin
        m_ext  = {1'b0, M};
        dbl    = {P, 1'b0};
        red1   = (dbl >= m_ext) ? (dbl - m_ext) : dbl;
        acc    = ybit ? (red1 + {1'b0, X}) : red1;
        P_next = (acc >= m_ext) ? WIDTH'(acc - m_ext) : acc[WIDTH-1:0];
    end

endmodule

// File: rtl/modmul_interleaved.sv
// Bit-serial (X*Y) mod M with valid/ready handshake, one Y bit per cycle.
// Define MODMUL_RANGE_CHECK_EN to flag out-of-range operands via out_err.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. Outputs
// stay stable while out_valid is high and out_ready is low.
module modmul_interleaved
    import modmul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int TAG_W = DEFAULT_TAG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Xin,
    input  logic [WIDTH-1:0] Yin,
    input  logic [WIDTH-1:0] Min,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output state_t           dbg_state
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH-1:0] m_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] p_next;
    logic [IDX_W-1:0] idx_r;
    logic [TAG_W-1:0] tag_r;
    logic             accept;
    logic             last_bit;
    logic             range_bad;

    assign accept   = in_valid && (state == IDLE);
    assign last_bit = (idx_r == '0);

`ifdef MODMUL_RANGE_CHECK_EN
    logic err_r;

    assign range_bad = (Xin >= Min) || (Yin >= Min) || (Min[WIDTH-1:1] == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (accept) begin
            err_r <= range_bad;
        end
    end

    assign out_err = err_r;
`else
    assign range_bad = 1'b0;
    assign out_err   = 1'b0;
`endif

    modmul_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .P     (p_r),
        .X     (x_r),
        .M     (m_r),
        .ybit  (y_r[idx_r]),
        .P_next(p_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = range_bad ? DONE : RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Q has its own register so it keeps the last result while a new
    // request reuses the accumulator.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_r   <= '0;
            x_r   <= '0;
            y_r   <= '0;
            m_r   <= '0;
            q_r   <= '0;
            idx_r <= '0;
            tag_r <= '0;
        end else if (accept) begin
            p_r   <= '0;
            x_r   <= Xin;
            y_r   <= Yin;
            m_r   <= Min;
            tag_r <= in_tag;
            idx_r <= IDX_W'(WIDTH - 1);
            if (range_bad) begin
                q_r <= '0;
            end
        end else if (state == RUN) begin
            p_r   <= p_next;
            idx_r <= idx_r - IDX_W'(1);
            if (last_bit) begin
                q_r <= p_next;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign Q         = q_r;
    assign out_tag   = tag_r;
    assign dbg_state = state;

endmodule
